// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demultiplexer: one producer steered by a 2-bit select
// into four single-entry holding registers, each with its own handshake and counter.
module demux_1to4_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data_0,
  output logic [DATA_WIDTH-1:0] out_data_1,
  output logic [DATA_WIDTH-1:0] out_data_2,
  output logic [DATA_WIDTH-1:0] out_data_3,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [CNT_WIDTH-1:0]  out_count_0,
  output logic [CNT_WIDTH-1:0]  out_count_1,
  output logic [CNT_WIDTH-1:0]  out_count_2,
  output logic [CNT_WIDTH-1:0]  out_count_3
);

  logic [DATA_WIDTH-1:0] data_r  [4];
  logic [CNT_WIDTH-1:0]  count_r [4];
  logic [3:0]            valid_r;
  logic                  in_ready_s;
  logic [3:0]            load_s;
  logic [3:0]            deliver_s;

  // Input acceptance: only the addressed channel can stall the producer.
  always_comb begin
    in_ready_s = ~valid_r[in_sel] | out_ready[in_sel];
    deliver_s  = valid_r & out_ready;
    if (in_valid && in_ready_s) begin
      load_s = 4'b0001 << in_sel;
    end else begin
      load_s = 4'b0000;
    end
  end

  // Holding registers, valid flags and delivered-word counters per channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        data_r[k]  <= {DATA_WIDTH{1'b0}};
        count_r[k] <= {CNT_WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load_s[k]) begin
          data_r[k] <= in_data;
        end
        // A reload on the delivering edge keeps the channel full (pass-through refill).
        valid_r[k] <= load_s[k] | (valid_r[k] & ~out_ready[k]);
        if (deliver_s[k]) begin
          count_r[k] <= count_r[k] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = valid_r;
  assign out_data_0  = data_r[0];
  assign out_data_1  = data_r[1];
  assign out_data_2  = data_r[2];
  assign out_data_3  = data_r[3];
  assign out_count_0 = count_r[0];
  assign out_count_1 = count_r[1];
  assign out_count_2 = count_r[2];
  assign out_count_3 = count_r[3];

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Directed bench for demux_1to4_stream: per-channel expected-word queues are the
// scoreboard; every cycle checks in_ready, valids, held data and counters.
module tb_demux_1to4_stream;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data_0, out_data_1, out_data_2, out_data_3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_count_0, out_count_1, out_count_2, out_count_3;

  logic [7:0] od [4];
  logic [7:0] oc [4];
  logic [7:0] exp_q [4][$];
  logic [7:0] cnt_m [4];
  int errors = 0;
  int checks = 0;

  assign od[0] = out_data_0;
  assign od[1] = out_data_1;
  assign od[2] = out_data_2;
  assign od[3] = out_data_3;
  assign oc[0] = out_count_0;
  assign oc[1] = out_count_1;
  assign oc[2] = out_count_2;
  assign oc[3] = out_count_3;

  demux_1to4_stream #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data_0(out_data_0), .out_data_1(out_data_1),
    .out_data_2(out_data_2), .out_data_3(out_data_3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_count_0(out_count_0), .out_count_1(out_count_1),
    .out_count_2(out_count_2), .out_count_3(out_count_3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      cnt_m[k] = 8'd0;
    end
  endtask

  // One clock: drive, check everything at the falling edge, update the model.
  task automatic cycle(input logic iv, input logic [1:0] sel, input logic [7:0] d,
                       input logic [3:0] ordy);
    logic exp_rdy;
    logic [3:0] exp_v;
    in_valid = iv; in_sel = sel; in_data = d; out_ready = ordy;
    @(negedge clk);
    exp_rdy = (exp_q[sel].size() == 0) || ordy[sel];
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    for (int k = 0; k < 4; k++) exp_v[k] = (exp_q[k].size() != 0);
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    for (int k = 0; k < 4; k++) begin
      if (exp_v[k]) chk($sformatf("out_data_%0d", k), 32'(od[k]), 32'(exp_q[k][0]));
      chk($sformatf("out_count_%0d", k), 32'(oc[k]), 32'(cnt_m[k]));
    end
    for (int k = 0; k < 4; k++) begin
      if (exp_v[k] && ordy[k]) begin
        void'(exp_q[k].pop_front());
        cnt_m[k] = cnt_m[k] + 8'd1;
      end
    end
    if (iv && exp_rdy) exp_q[sel].push_back(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'd0; out_ready = 4'd0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data2", 32'(out_data_2), 32'h0);
    chk("rst_count0", 32'(out_count_0), 32'h0);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // 1: single word to channel 2
    cycle(1'b1, 2'd2, 8'hA5, 4'b0000);
    cycle(1'b0, 2'd0, 8'h00, 4'b0000);
    chk("t1_valid", 32'(out_valid), 32'h4);
    chk("t1_data2", 32'(out_data_2), 32'hA5);

    // 2: full channel stalls only itself
    cycle(1'b1, 2'd2, 8'h3C, 4'b0000);
    chk("t2_data2_held", 32'(out_data_2), 32'hA5);
    cycle(1'b1, 2'd1, 8'h11, 4'b0000);
    cycle(1'b0, 2'd0, 8'h00, 4'b0000);
    chk("t2_valid", 32'(out_valid), 32'h6);

    // 3: streaming on channel 0
    for (int i = 1; i <= 5; i++) cycle(1'b1, 2'd0, 8'(i), 4'b0001);
    cycle(1'b0, 2'd0, 8'h00, 4'b0001);
    cycle(1'b0, 2'd0, 8'h00, 4'b0001);
    chk("t3_count0", 32'(out_count_0), 32'h5);

    // 4: deliver and reload on the same edge
    cycle(1'b1, 2'd3, 8'hF0, 4'b0000);
    cycle(1'b1, 2'd3, 8'h0F, 4'b1000);
    cycle(1'b0, 2'd0, 8'h00, 4'b0000);
    chk("t4_valid3", 32'(out_valid[3]), 32'h1);
    chk("t4_data3", 32'(out_data_3), 32'h0F);
    chk("t4_count3", 32'(out_count_3), 32'h1);

    // 6: asynchronous reset with channels 0,1,3 occupied
    cycle(1'b0, 2'd0, 8'h00, 4'b0100);
    cycle(1'b1, 2'd0, 8'h77, 4'b0000);
    cycle(1'b0, 2'd0, 8'h00, 4'b0000);
    chk("t6_valid_pre", 32'(out_valid), 32'hB);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_valid_rst", 32'(out_valid), 32'h0);
    chk("t6_data3_rst", 32'(out_data_3), 32'h0);
    chk("t6_count3_rst", 32'(out_count_3), 32'h0);
    chk("t6_count0_rst", 32'(out_count_0), 32'h0);
    model_clear();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle(1'b1, 2'd1, 8'h5A, 4'b0000);
    cycle(1'b0, 2'd0, 8'h00, 4'b0000);
    chk("t6_after_data1", 32'(out_data_1), 32'h5A);

    // 5: counter wrap on channel 1, starting from a fresh reset
    #2;
    reset_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 256; i++) cycle(1'b1, 2'd1, 8'(i), 4'b0010);
    cycle(1'b0, 2'd0, 8'h00, 4'b0010);
    cycle(1'b0, 2'd0, 8'h00, 4'b0010);
    chk("t5_wrap256", 32'(out_count_1), 32'h0);
    cycle(1'b1, 2'd1, 8'hEE, 4'b0010);
    cycle(1'b0, 2'd0, 8'h00, 4'b0010);
    cycle(1'b0, 2'd0, 8'h00, 4'b0010);
    chk("t5_wrap257", 32'(out_count_1), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
